dmem_reg_path: RTL and testbench
================================

# dmem_reg_path

Parametrised data-memory / register-file datapath: one command port moves data between an internal synchronous-read data memory and a multi-ported register file, under a small FSM with valid/ready handshake and a completion pulse. It sits between instruction decode and the ALU and supplies the two operand read ports (A, B) the ALU consumes. Compared with the fixed 16-bit block, it adds configurable width and depth, MOVE, address-range checking, write-to-read bypass, and defined reset behaviour.

## Interface
- DATA_W, 16: data word width for memory and registers
- DMEM_DEPTH, 256: data memory words; need not be a power of two
- REG_COUNT, 32: number of registers
- DADDR_W, 8: command address width; must satisfy 2^DADDR_W >= DMEM_DEPTH
- RADDR_W, $clog2(REG_COUNT): register index width (derived)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears FSM, register file and flags
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  2  operation code, from the package: NOP=0, LOAD=1, STORE=2, MOVE=3
- cmd_addr  in  DADDR_W  data memory address (LOAD/STORE)
- cmd_wreg  in  RADDR_W  destination register (LOAD/MOVE)
- cmd_sreg  in  RADDR_W  source register (STORE/MOVE)
- rd_addr_a  in  RADDR_W  read port A index
- rd_addr_b  in  RADDR_W  read port B index
- rd_data_a  out  DATA_W  register A, combinational, with bypass
- rd_data_b  out  DATA_W  register B, combinational, with bypass
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse coincident with done when the address is out of range

## Operation
- FSM states: IDLE and LOAD_WB. cmd_ready = (state == IDLE).
- Accept occurs on an edge with cmd_valid && cmd_ready.
- NOP: no state change; done pulses the next cycle.
- STORE: at the accept edge, mem[cmd_addr] <= RF[cmd_sreg]. The FSM stays in IDLE.
- MOVE: at the accept edge, RF[cmd_wreg] <= RF[cmd_sreg]. The FSM stays in IDLE.
- LOAD: at the accept edge, the memory read address is registered and the FSM goes IDLE -> LOAD_WB. In LOAD_WB the memory q is valid. At the end of LOAD_WB, RF[cmd_wreg] <= q and the FSM returns to IDLE.
- Out-of-range address (cmd_addr >= DMEM_DEPTH):
  - STORE: memory is untouched.
  - LOAD: writes 0 to the destination register.
  - Both: err pulses with done.
- Bypass: while an RF write is in progress this cycle (MOVE accept, or LOAD_WB), a read port whose index equals the write index returns the write data, not the stale content.
- Read ports are independent of the command port and valid in every state.
- The memory has no reset; its contents survive reset. The register file clears to 0 on reset.

## Timing
- Reset values: state = IDLE, done = 0, err = 0, all registers = 0. rd_data_a/b therefore read 0. cmd_ready reads 1 once the FSM is in IDLE; commands presented while reset is high are ignored.
- Latency from accept edge to the done-high cycle:
  - NOP, STORE, MOVE: 1 cycle; back-to-back accepts are allowed every cycle.
  - LOAD: 2 cycles; cmd_ready is low for exactly 1 cycle (LOAD_WB).
- Register read-after-write through the ports: new data is visible combinationally in the write cycle (bypass) and from the array in the next cycle.
- Memory read-after-write: a STORE followed immediately by a LOAD to the same address returns the stored value (the write lands at the STORE accept edge; the read address is registered at the later edge).
- STORE with cmd_sreg written by the immediately preceding command reads the updated value: the RF is already updated at the accept edge.
- Reset asserted during LOAD_WB: the FSM goes to IDLE, no RF write occurs, and neither done nor err pulses.
- cmd_valid while cmd_ready is low: the command is not consumed; the source holds it.

## Structure
- Package dmem_reg_pkg holds the op enum (NOP, LOAD, STORE, MOVE), the FSM state enum (IDLE, LOAD_WB) and the default width constants.
- Sub-module reg_file_2r1w (parameters DATA_W, REG_COUNT): async-reset array, one write port, two combinational read ports with write bypass. MOVE's source read uses a third internal read tap.
- Data memory is inferred inline: synchronous write, registered read address, no reset.

## Test plan
- Reset, then read ports A=1, B=2 -> both 0; cmd_ready=1; done=0.
- MOVE r3<-r0 (r0 preset to 0x0000 via LOAD of mem[5]=0x0000), then STORE mem[0x10]<-r3, then LOAD r7<-mem[0x10] -> r7=0x0000. Repeat with mem[5] preloaded as 0xBEEF -> r7=0xBEEF. Done 1 cycle after each accept (2 for LOAD). cmd_ready low exactly 1 cycle per LOAD.
- LOAD r4<-mem[0x20]=0x1234 with rd_addr_a=4 held -> rd_data_a shows 0x1234 during the LOAD_WB cycle (bypass) and after.
- DMEM_DEPTH=200: STORE to addr 200 -> mem unchanged, err=1 with done. LOAD r2 from addr 255 -> r2=0, err=1.
- Reset pulsed during LOAD_WB -> no done, target register 0, FSM IDLE; memory contents retained (a later LOAD returns the pre-reset value).
- STORE to addr 9 and LOAD from addr 9 on consecutive cycles -> the LOAD returns the stored value.

Source files
------------

// File: rtl/dmem_reg_pkg.sv
// Shared types and default sizes for the data-memory / register-file datapath.
package dmem_reg_pkg;
    localparam int DATA_W_DEF     = 16;
    localparam int DMEM_DEPTH_DEF = 256;
    localparam int REG_COUNT_DEF  = 32;
    localparam int DADDR_W_DEF    = 8;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        MOVE  = 2'd3
    } op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        LOAD_WB = 1'b1
    } state_e;
endpackage

// File: rtl/reg_file_2r1w.sv
// Register file: async-reset array, one write port, two bypassed read ports
// and one raw internal read tap used as the command source operand.
module reg_file_2r1w #(
    parameter int DATA_W    = 16,
    parameter int REG_COUNT = 32,
    parameter int RADDR_W   = $clog2(REG_COUNT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [RADDR_W-1:0] raddr_a,
    input  logic [RADDR_W-1:0] raddr_b,
    input  logic [RADDR_W-1:0] raddr_c,
    output logic [DATA_W-1:0]  rdata_a,
    output logic [DATA_W-1:0]  rdata_b,
    output logic [DATA_W-1:0]  rdata_c
);
    logic [DATA_W-1:0] regs [REG_COUNT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // ALU ports see the value being written this cycle rather than the stale entry.
    assign rdata_a = (we && waddr == raddr_a) ? wdata : regs[raddr_a];
    assign rdata_b = (we && waddr == raddr_b) ? wdata : regs[raddr_b];
    assign rdata_c = regs[raddr_c];
endmodule

// File: rtl/dmem_reg_path.sv
// Command-driven datapath moving words between a synchronous-read data memory
// and the register file; LOAD takes one extra write-back cycle.
module dmem_reg_path
    import dmem_reg_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter int REG_COUNT  = REG_COUNT_DEF,
    parameter int DADDR_W    = DADDR_W_DEF,
    parameter int RADDR_W    = $clog2(REG_COUNT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [DADDR_W-1:0] cmd_addr,
    input  logic [RADDR_W-1:0] cmd_wreg,
    input  logic [RADDR_W-1:0] cmd_sreg,
    input  logic [RADDR_W-1:0] rd_addr_a,
    input  logic [RADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]  rd_data_a,
    output logic [DATA_W-1:0]  rd_data_b,
    output logic               done,
    output logic               err
);
    localparam int MEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [DADDR_W:0] DEPTH_LIM = (DADDR_W + 1)'(DMEM_DEPTH);

    state_e             state_reg, state_next;
    op_e                op;
    logic               accept, addr_ok;
    logic [MEM_AW-1:0]  mem_idx, mem_raddr_reg;
    logic [DATA_W-1:0]  mem [DMEM_DEPTH];
    logic [DATA_W-1:0]  mem_q, src_data, rf_wdata;
    logic [RADDR_W-1:0] wreg_reg, rf_waddr;
    logic               load_oor_reg, rf_we;
    logic               done_reg, done_next, err_reg, err_next;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state_reg == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign addr_ok   = {1'b0, cmd_addr} < DEPTH_LIM;
    assign mem_idx   = cmd_addr[MEM_AW-1:0];

    // No reset on the array: contents persist across reset.
    always_ff @(posedge clk) begin
        if (accept && op == STORE && addr_ok) begin
            mem[mem_idx] <= src_data;
        end
        if (accept && op == LOAD) begin
            mem_raddr_reg <= mem_idx;
        end
    end
    assign mem_q = mem[mem_raddr_reg];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            wreg_reg     <= '0;
            load_oor_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            if (accept && op == LOAD) begin
                wreg_reg     <= cmd_wreg;
                load_oor_reg <= !addr_ok;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = cmd_wreg;
        rf_wdata   = src_data;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        NOP:   done_next = 1'b1;
                        STORE: begin
                            done_next = 1'b1;
                            err_next  = !addr_ok;
                        end
                        MOVE:  begin
                            done_next = 1'b1;
                            rf_we     = 1'b1;
                        end
                        LOAD:  state_next = LOAD_WB;
                        default: ;
                    endcase
                end
            end
            LOAD_WB: begin
                // An out-of-range load still completes, writing zero.
                state_next = IDLE;
                done_next  = 1'b1;
                err_next   = load_oor_reg;
                rf_we      = 1'b1;
                rf_waddr   = wreg_reg;
                rf_wdata   = load_oor_reg ? '0 : mem_q;
            end
            default: state_next = IDLE;
        endcase
    end

    reg_file_2r1w #(
        .DATA_W   (DATA_W),
        .REG_COUNT(REG_COUNT),
        .RADDR_W  (RADDR_W)
    ) u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr_a(rd_addr_a),
        .raddr_b(rd_addr_b),
        .raddr_c(cmd_sreg),
        .rdata_a(rd_data_a),
        .rdata_b(rd_data_b),
        .rdata_c(src_data)
    );

    assign done = done_reg;
    assign err  = err_reg;
endmodule

// File: tb/tb_dmem_reg_path.sv
// Bench for dmem_reg_path: directed vector table, reset-during-load sequence
// and randomized commands against a transaction-level model.
module tb_dmem_reg_path;
    import dmem_reg_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 200;
    localparam int RC    = 32;
    localparam int AW    = 8;
    localparam int RW    = 5;

    logic          clk, reset, cmd_valid, cmd_ready, done, err;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [RW-1:0] cmd_wreg, cmd_sreg, rd_addr_a, rd_addr_b;
    logic [DW-1:0] rd_data_a, rd_data_b;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_rf  [RC];
    logic [DW-1:0] model_mem [256];

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [RW-1:0] wreg;
        logic [RW-1:0] sreg;
        logic [RW-1:0] ra;
        logic [DW-1:0] exp_a;
        logic [RW-1:0] rb;
        logic [DW-1:0] exp_b;
        logic          exp_err;
    } vec_t;

    vec_t vecs [19];

    dmem_reg_path #(
        .DATA_W    (DW),
        .DMEM_DEPTH(DEPTH),
        .REG_COUNT (RC),
        .DADDR_W   (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_wreg (cmd_wreg),
        .cmd_sreg (cmd_sreg),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .done     (done),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_cycle();
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        @(posedge clk);
        @(negedge clk);
        chk("idle_done", {31'd0, done}, 32'd0);
    endtask

    // Called just after a falling edge; returns at the falling edge where done is expected,
    // leaving cmd_valid high so the caller chooses back-to-back or idle.
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [RW-1:0] wreg, input logic [RW-1:0] sreg);
        logic          in_range;
        logic          exp_err;
        logic [DW-1:0] exp_val;
        in_range  = int'(addr) < DEPTH;
        exp_err   = (op == LOAD || op == STORE) && !in_range;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wreg  = wreg;
        cmd_sreg  = sreg;
        rd_addr_b = wreg;
        #1;
        chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
        exp_val = (op == MOVE) ? model_rf[sreg] : model_rf[wreg];
        chk("accept_cycle_rd_b", {16'd0, rd_data_b}, {16'd0, exp_val});
        @(posedge clk);
        @(negedge clk);
        if (op == LOAD) begin
            exp_val = in_range ? model_mem[addr] : '0;
            chk("load_wb_ready", {31'd0, cmd_ready}, 32'd0);
            chk("load_wb_done", {31'd0, done}, 32'd0);
            rd_addr_a = wreg;
            #1;
            chk("load_bypass", {16'd0, rd_data_a}, {16'd0, exp_val});
            @(posedge clk);
            @(negedge clk);
            model_rf[wreg] = exp_val;
        end else if (op == MOVE) begin
            model_rf[wreg] = model_rf[sreg];
        end else if (op == STORE && in_range) begin
            model_mem[addr] = model_rf[sreg];
        end
        chk("done", {31'd0, done}, 32'd1);
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("ready_after", {31'd0, cmd_ready}, 32'd1);
        $display("cmd op=%0d addr=%0d wreg=%0d sreg=%0d done=%0b err=%0b",
                 op, addr, wreg, sreg, done, err);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_addr  = '0;
        cmd_wreg  = '0;
        cmd_sreg  = '0;
        rd_addr_a = 5'd1;
        rd_addr_b = 5'd2;
        for (int i = 0; i < RC; i++) model_rf[i] = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = DW'($urandom);
        model_mem[5]   = 16'h0000;
        model_mem[6]   = 16'hBEEF;
        model_mem[9]   = 16'h3C3C;
        model_mem[32]  = 16'h1234;
        model_mem[48]  = 16'h00A5;
        model_mem[72]  = 16'h0C48;
        model_mem[199] = 16'h7777;
        for (int i = 0; i < DEPTH; i++) dut.mem[i] = model_mem[i];

        vecs[0]  = '{LOAD,  8'd5,   5'd0,  5'd0,  5'd0,  16'h0000, 5'd1,  16'h0000, 1'b0};
        vecs[1]  = '{MOVE,  8'd0,   5'd3,  5'd0,  5'd3,  16'h0000, 5'd0,  16'h0000, 1'b0};
        vecs[2]  = '{STORE, 8'h10,  5'd0,  5'd3,  5'd3,  16'h0000, 5'd7,  16'h0000, 1'b0};
        vecs[3]  = '{LOAD,  8'h10,  5'd7,  5'd0,  5'd7,  16'h0000, 5'd3,  16'h0000, 1'b0};
        vecs[4]  = '{LOAD,  8'd6,   5'd0,  5'd0,  5'd0,  16'hBEEF, 5'd7,  16'h0000, 1'b0};
        vecs[5]  = '{MOVE,  8'd0,   5'd3,  5'd0,  5'd3,  16'hBEEF, 5'd0,  16'hBEEF, 1'b0};
        vecs[6]  = '{STORE, 8'h10,  5'd0,  5'd3,  5'd3,  16'hBEEF, 5'd7,  16'h0000, 1'b0};
        vecs[7]  = '{LOAD,  8'h10,  5'd7,  5'd0,  5'd7,  16'hBEEF, 5'd3,  16'hBEEF, 1'b0};
        vecs[8]  = '{LOAD,  8'h20,  5'd4,  5'd0,  5'd4,  16'h1234, 5'd7,  16'hBEEF, 1'b0};
        vecs[9]  = '{STORE, 8'd200, 5'd0,  5'd7,  5'd7,  16'hBEEF, 5'd4,  16'h1234, 1'b1};
        vecs[10] = '{LOAD,  8'd72,  5'd9,  5'd0,  5'd9,  16'h0C48, 5'd10, 16'h0000, 1'b0};
        vecs[11] = '{LOAD,  8'd199, 5'd10, 5'd0,  5'd10, 16'h7777, 5'd9,  16'h0C48, 1'b0};
        vecs[12] = '{LOAD,  8'h20,  5'd2,  5'd0,  5'd2,  16'h1234, 5'd11, 16'h0000, 1'b0};
        vecs[13] = '{LOAD,  8'd255, 5'd2,  5'd0,  5'd2,  16'h0000, 5'd4,  16'h1234, 1'b1};
        vecs[14] = '{NOP,   8'd255, 5'd0,  5'd0,  5'd2,  16'h0000, 5'd7,  16'hBEEF, 1'b0};
        vecs[15] = '{STORE, 8'd9,   5'd0,  5'd4,  5'd4,  16'h1234, 5'd0,  16'hBEEF, 1'b0};
        vecs[16] = '{LOAD,  8'd9,   5'd11, 5'd0,  5'd11, 16'h1234, 5'd4,  16'h1234, 1'b0};
        vecs[17] = '{MOVE,  8'd0,   5'd0,  5'd11, 5'd0,  16'h1234, 5'd3,  16'hBEEF, 1'b0};
        vecs[18] = '{MOVE,  8'd0,   5'd12, 5'd9,  5'd12, 16'h0C48, 5'd9,  16'h0C48, 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_rd_a", {16'd0, rd_data_a}, 32'd0);
        chk("reset_rd_b", {16'd0, rd_data_b}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);

        // Directed table, applied back-to-back
        for (int v = 0; v < 19; v++) begin
            run_cmd(vecs[v].op, vecs[v].addr, vecs[v].wreg, vecs[v].sreg);
            chk("tbl_err", {31'd0, err}, {31'd0, vecs[v].exp_err});
            rd_addr_a = vecs[v].ra;
            rd_addr_b = vecs[v].rb;
            #1;
            chk("tbl_rd_a", {16'd0, rd_data_a}, {16'd0, vecs[v].exp_a});
            chk("tbl_rd_b", {16'd0, rd_data_b}, {16'd0, vecs[v].exp_b});
        end
        idle_cycle();

        // Reset asserted in the LOAD_WB cycle
        cmd_valid = 1'b1;
        cmd_op    = LOAD;
        cmd_addr  = 8'h30;
        cmd_wreg  = 5'd5;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wb_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("rst_wb_ready_async", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_wb_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < RC; i++) model_rf[i] = '0;
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd4;
        #1;
        chk("rst_wb_done_after", {31'd0, done}, 32'd0);
        chk("rst_wb_err_after", {31'd0, err}, 32'd0);
        chk("rst_wb_target", {16'd0, rd_data_a}, 32'd0);
        chk("rst_wb_rf_cleared", {16'd0, rd_data_b}, 32'd0);
        run_cmd(LOAD, 8'h30, 5'd6, 5'd0);
        rd_addr_a = 5'd6;
        #1;
        chk("mem_kept_30", {16'd0, rd_data_a}, 32'h00A5);
        run_cmd(LOAD, 8'h10, 5'd7, 5'd0);
        rd_addr_a = 5'd7;
        #1;
        chk("mem_kept_10", {16'd0, rd_data_a}, 32'hBEEF);
        idle_cycle();

        // Randomized commands against the model
        for (int n = 0; n < 300; n++) begin
            logic [1:0]    r_op;
            logic [AW-1:0] r_addr;
            logic [RW-1:0] r_w, r_s;
            r_op   = 2'($urandom_range(0, 3));
            r_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(200, 255))
                                                 : AW'($urandom_range(0, 199));
            r_w    = RW'($urandom);
            r_s    = RW'($urandom);
            run_cmd(r_op, r_addr, r_w, r_s);
            if ($urandom_range(0, 2) == 0) idle_cycle();
            rd_addr_a = RW'($urandom);
            rd_addr_b = RW'($urandom);
            #1;
            chk("rand_rd_a", {16'd0, rd_data_a}, {16'd0, model_rf[rd_addr_a]});
            chk("rand_rd_b", {16'd0, rd_data_b}, {16'd0, model_rf[rd_addr_b]});
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
